// File: rtl/trace_record_packer.sv
// Packs dual-issue lane events into 32-bit trace words and streams them out of a FIFO.
// Optional marker words recording drop bursts are enabled with `define TRACE_DROP_MARKER_EN.
module trace_record_packer #(
    parameter int DEPTH      = 16,
    parameter int FILTER_NOP = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     a_valid,
    input  logic [3:0]               a_instr,
    input  logic [4:0]               a_alu,
    input  logic [3:0]               a_haz,
    input  logic [31:0]              a_pc,
    input  logic                     b_valid,
    input  logic [3:0]               b_instr,
    input  logic [4:0]               b_alu,
    input  logic [3:0]               b_haz,
    input  logic [31:0]              b_pc,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    seq_q, seq_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
`ifdef TRACE_DROP_MARKER_EN
    logic [15:0]   marker_cnt_q, marker_cnt_d;
    logic          marker_wr;
`endif

    logic          pop;
    logic          a_cand, b_cand;
    logic [CW-1:0] kept, free;
    logic [31:0]   a_word, b_word;
    logic [31:0]   word0, word1;
    logic [1:0]    n_wr, n_drop;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^{a_pc[31:12], a_pc[1:0], b_pc[31:12], b_pc[1:0]};

    function automatic logic is_candidate(input logic v, input logic en, input logic [3:0] instr);
        logic nop_skip;
        nop_skip     = (FILTER_NOP != 0) && (instr == 4'd10);
        is_candidate = v && en && (instr <= 4'd11) && !nop_skip;
    endfunction

    function automatic logic [31:0] pack_word(input logic [3:0] instr, input logic [4:0] alu,
                                              input logic [3:0] haz, input logic lane,
                                              input logic [7:0] seq, input logic [9:0] pc_bits);
        pack_word = {instr, alu, haz, lane, seq, pc_bits};
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base} + {15'd0, inc};
        if (sum[16]) begin
            sat_add16 = 16'hFFFF;
        end else begin
            sat_add16 = sum[15:0];
        end
    endfunction

    // Next-state: candidate selection, space test after this cycle's pop, head word.
    always_comb begin
        pop    = out_valid_q & out_ready;
        kept   = count_q - CW'(pop);
        free   = CW'(DEPTH) - kept;
        a_cand = is_candidate(a_valid, trace_en, a_instr);
        b_cand = is_candidate(b_valid, trace_en, b_instr);
        a_word = pack_word(a_instr, a_alu, a_haz, 1'b0, seq_q, a_pc[11:2]);
        b_word = pack_word(b_instr, b_alu, b_haz, 1'b1, seq_q + {7'd0, a_cand}, b_pc[11:2]);
        seq_d  = seq_q + {7'd0, a_cand} + {7'd0, b_cand};
        word0  = 32'd0;
        word1  = 32'd0;
        n_wr   = 2'd0;
        n_drop = 2'd0;
`ifdef TRACE_DROP_MARKER_EN
        marker_wr = 1'b0;
`endif
        case ({a_cand, b_cand})
            2'b11: begin
                if (free >= CW'(2)) begin
                    word0 = a_word;
                    word1 = b_word;
                    n_wr  = 2'd2;
                end else if (free == CW'(1)) begin
                    word0  = a_word;
                    n_wr   = 2'd1;
                    n_drop = 2'd1;
                end else begin
                    n_drop = 2'd2;
                end
            end
            2'b10: begin
                if (free != CW'(0)) begin
                    word0 = a_word;
                    n_wr  = 2'd1;
                end else begin
                    n_drop = 2'd1;
                end
            end
            2'b01: begin
                if (free != CW'(0)) begin
                    word0 = b_word;
                    n_wr  = 2'd1;
                end else begin
                    n_drop = 2'd1;
                end
            end
            default: begin
`ifdef TRACE_DROP_MARKER_EN
                // Idle cycle with space: flush the pending drop tally as a marker word.
                if ((marker_cnt_q != 16'd0) && (free != CW'(0))) begin
                    word0     = {4'hF, 12'h000, marker_cnt_q};
                    n_wr      = 2'd1;
                    marker_wr = 1'b1;
                end else begin
                    marker_wr = 1'b0;
                end
`else
                n_wr = 2'd0;
`endif
            end
        endcase

`ifdef TRACE_DROP_MARKER_EN
        if (marker_wr) begin
            marker_cnt_d = 16'd0;
        end else begin
            marker_cnt_d = sat_add16(marker_cnt_q, n_drop);
        end
`endif
        overflow_d  = overflow_q | (n_drop != 2'd0);
        drop_cnt_d  = sat_add16(drop_cnt_q, n_drop);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        wr_ptr_d    = wr_ptr_q + AW'(n_wr);
        count_d     = kept + CW'(n_wr);
        out_valid_d = (count_d != CW'(0));
        // When nothing survives the pop, the first word written this cycle becomes the head.
        if (kept != CW'(0)) begin
            out_data_d = mem_q[rd_ptr_d];
        end else if (n_wr != 2'd0) begin
            out_data_d = word0;
        end else begin
            out_data_d = 32'd0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            seq_q        <= 8'd0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= 16'd0;
            out_data_q   <= 32'd0;
            out_valid_q  <= 1'b0;
`ifdef TRACE_DROP_MARKER_EN
            marker_cnt_q <= 16'd0;
`endif
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            seq_q        <= seq_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
`ifdef TRACE_DROP_MARKER_EN
            marker_cnt_q <= marker_cnt_d;
`endif
        end
    end

    // FIFO storage; A is written before B at consecutive slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            if (n_wr != 2'd0) begin
                mem_q[wr_ptr_q] <= word0;
            end
            if (n_wr == 2'd2) begin
                mem_q[wr_ptr_q + AW'(1)] <= word1;
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign occupancy  = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: doc/trace_record_packer.md
Name: trace_record_packer

Overview:
- Write side of the team's waveform/trace debug path. The enum helper package decodes packed vectors back into `instruction_t`, `alu_op_t` and `hazard_signal_t`; this block produces those packed vectors.
- Captures per-lane issue events from the dual-issue pipeline (lanes A and B) and packs each into a 32-bit trace word using the same enum encodings.
- Buffers words in a FIFO and streams them out over a valid/ready interface to a trace sink (BRAM logger or UART bridge).

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥4.
- FILTER_NOP, 1, when 1 records with instr code NOP_i (4'd10) are silently skipped (not stored, not counted as drops).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- trace_en  in  1  capture enable; when 0 no records are captured and seq does not advance.
- a_valid  in  1  lane A issue event this cycle.
- a_instr  in  4  lane A instruction_t code.
- a_alu  in  5  lane A alu_op_t code.
- a_haz  in  4  lane A hazard_signal_t code.
- a_pc  in  32  lane A PC.
- b_valid, b_instr, b_alu, b_haz, b_pc  in  1/4/5/4/32  lane B, same meaning.
- out_data  out  32  trace word at FIFO head.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts word.
- occupancy  out  $clog2(DEPTH)+1  stored words.
- overflow  out  1  sticky; set on any drop, cleared only by reset.
- drop_count  out  16  saturating count of dropped records.

Behaviour:
- Word layout:
  - [31:28] instr
  - [27:23] alu
  - [22:19] haz
  - [18] lane (0=A, 1=B)
  - [17:10] seq
  - [9:0] pc[11:2]
- Candidate record: lane valid & trace_en & instr ≤ 4'd11 & !(FILTER_NOP & instr==4'd10).
- Invalid instr codes (>11) are ignored entirely: no store, no drop, no seq advance.
- seq (8-bit) is assigned per candidate: A gets seq, B gets seq+1 when both are candidates.
  - seq advances by the number of candidates, mod 256 wrap.
  - Dropped records still consume a seq value, so gaps in seq reveal drops.
- Write order: A before B in the same cycle.
- Space test uses occupancy after this cycle's pop. A same-cycle pop (out_valid & out_ready) frees one slot for a same-cycle write.
  - Free ≥ 2: both stored.
  - Free == 1: A stored, B dropped.
  - Free == 0: both dropped.
- Each drop sets overflow and increments drop_count, saturating at 16'hFFFF. Two drops in one cycle add 2, still saturating.
- Latency: record captured at edge N appears on out_data/out_valid after edge N if the FIFO was empty. No combinational path from inputs to outputs.
- out_data is held stable while out_valid & !out_ready.
- Pointers wrap modulo DEPTH. occupancy ranges 0..DEPTH.
- Reset (any time, including mid-stream):
  - FIFO emptied; out_valid=0, out_data=0, occupancy=0.
  - seq=0, overflow=0, drop_count=0.
  - In-flight words are lost.
- trace_en deasserted mid-stream: the FIFO continues draining; no new captures.

Optional Feature:
- TRACE_DROP_MARKER_EN
- Defined:
  - On the first cycle after one or more drops where at least one slot is free and no candidate is present, write a marker word: [31:28]=4'hF, [27:16]=0, [15:0]=drops since last marker (saturating).
  - The per-marker counter then clears. drop_count output is unaffected.
  - Markers do not consume seq.
  - Candidates take priority over markers.
- Undefined: no marker words are generated; 4'hF never appears in [31:28].

Test Plan:
- Single A record, instr=R_TYPE_i(0), alu=ALU_SUB(1), haz=NONE_h(9), pc=0x0000_0104, out_ready=1 → out_valid one cycle later, out_data=0x00C8_0041 (seq 0); occupancy returns to 0.
- A and B both valid for 3 cycles, out_ready=1 → 6 words in order A,B,A,B,A,B with seq 0..5 and lane bit alternating.
- DEPTH=16, out_ready=0, both lanes valid with R_TYPE_i for 9 cycles → 16 stored; cycle 8 drops both; overflow=1, drop_count=2; drained words have seq 0..15.
- occupancy=15, a_valid & b_valid, out_ready=1 with a pop the same cycle → both stored, occupancy=16, no drop.
- FILTER_NOP=1, a_instr=NOP_i(10), b_instr=LOAD_i(2) → only the B word is stored, with seq 0; seq then =1.
- reset asserted asynchronously with 5 words stored → outputs clear immediately. With TRACE_DROP_MARKER_EN after the 2-drop overflow, an idle cycle with space yields marker 0xF000_0002.
